serial_word_rx: RTL and testbench

Bit-serial frame receiver with an output word buffer. It samples a framed serial line on a strobe, checks the start, parity and stop bits, and assembles data bits MSB-first into words. Good words are pushed into a DEPTH-entry buffer and drained over a valid/ready interface. It is the receive end of the team's bit-serial word link and sits between the pin-level sampler, which supplies `bit_en`, and the word-level consumer.

---
 rtl/serial_link_pkg.sv | 19 +
 rtl/serial_word_rx_if.sv | 11 +
 rtl/serial_word_fifo.sv | 49 ++++
 rtl/serial_word_rx.sv | 109 ++++++++++
 tb/tb_serial_word_rx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types, framing constants and parity helper for the bit-serial word link
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit that makes the total number of ones even; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_word_rx_if.sv
// rtl/serial_word_rx_if.sv - valid/ready word stream from the receiver buffer to the consumer
interface serial_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/serial_word_fifo.sv
// rtl/serial_word_fifo.sv - circular word buffer with registered occupancy and combinational head
module serial_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   room,
  output logic [$clog2(DEPTH):0] count,
  serial_word_rx_if.master       out
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop;
  logic             full;

  assign pop           = out.out_valid && out.out_ready;
  assign full          = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot the incoming push needs.
  assign room          = !full || pop;
  assign out.out_valid = (count != '0);
  assign out.out_data  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - framed serial receiver feeding a word buffer; parity checking under SERIAL_WORD_RX_PARITY_EN
module serial_word_rx
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_en,
  input  logic                   bit_in,
  serial_word_rx_if.master       out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overflow
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             frame_bad;
  logic             stop_good;
  logic             stop_bad;
  logic             room;
  logic             push;

`ifdef SERIAL_WORD_RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          par_bad <= 1'b0;
    else if (bit_en && state == PARITY) par_bad <= (even_parity(64'(shreg)) != bit_in);
  end

  assign frame_bad = (bit_in != STOP_BIT) || par_bad;
`else
  assign frame_bad = (bit_in != STOP_BIT);
`endif

  assign push = stop_good && room;

  always_comb begin
    state_d   = state;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: if (bit_in == START_BIT) state_d = DATA;
        DATA: if (cnt == CNT_LAST) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d   = IDLE;
          stop_bad  = frame_bad;
          stop_good = !frame_bad;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      frame_err <= stop_bad;
      overflow  <= stop_good && !room;
      if (bit_en) begin
        case (state)
          IDLE: if (bit_in == START_BIT) begin
            cnt   <= '0;
            shreg <= '0;
          end
          DATA: begin
            shreg <= {shreg[WIDTH-2:0], bit_in};
            cnt   <= cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  serial_word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .room      (room),
    .count     (count),
    .out       (out)
  );

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - randomized scoreboard bench for serial_word_rx
module tb_serial_word_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;

  typedef struct {
    int   cyc;
    logic fe;
    logic ov;
  } pulse_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   bit_en = 1'b0;
  logic                   bit_in = 1'b1;
  logic [$clog2(DEPTH):0] count;
  logic                   frame_err;
  logic                   overflow;

  serial_word_rx_if #(.WIDTH(WIDTH)) bus ();

  serial_word_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .bit_in    (bit_in),
    .out       (bus),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned      vec = 0;
  int unsigned      bad = 0;
  int               cyc = 0;
  int               rdy_mode = 0;
  logic             in_rst = 1'b1;
  int               pend = 0;
  logic [WIDTH-1:0] wq[$];
  pulse_t           pq[$];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples 2 time units after the falling edge, after stimulus has settled.
  initial begin
    logic             efe, eov;
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst) begin
        efe = 1'b0;
        eov = 1'b0;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
          efe = pq[0].fe;
          eov = pq[0].ov;
          void'(pq.pop_front());
        end
        if (efe || eov || frame_err || overflow)
          chk("pulses{frame_err,overflow}", {frame_err, overflow}, {efe, eov});
        chk("count", count, wq.size() - pend);
        chk("out_valid", bus.out_valid, (wq.size() - pend) > 0);
        pend = 0;
        if (bus.out_valid && bus.out_ready) begin
          if (wq.size() == 0) chk("unexpected_pop", 1, 0);
          else begin
            w = wq.pop_front();
            chk("out_data", bus.out_data, w);
          end
        end
      end
    end
  end

  task automatic drive(input logic en, input logic b, input logic stop_cycle);
    @(negedge clk);
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = stop_cycle;
    endcase
    bit_en = en;
    bit_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop_ok,
                            input logic par_ok, input int gap);
    logic bits[$];
    logic good;
    pulse_t p;
    bits.push_back(1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(w[i]);
`ifdef SERIAL_WORD_RX_PARITY_EN
    bits.push_back((^w) ^ !par_ok);
    good = stop_ok && par_ok;
`else
    good = stop_ok;
`endif
    bits.push_back(stop_ok);
    for (int k = 0; k < bits.size(); k++) begin
      repeat (gap) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      drive(1'b1, bits[k], k == bits.size() - 1);
    end
    p.cyc = cyc + 1;
    p.fe  = 1'b0;
    p.ov  = 1'b0;
    if (!good) begin
      p.fe = 1'b1;
      pq.push_back(p);
    end else if (wq.size() < DEPTH || (bus.out_ready && wq.size() > 0)) begin
      wq.push_back(w);
      pend = 1;
    end else begin
      p.ov = 1'b1;
      pq.push_back(p);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] w77;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    in_rst = 1'b0;

    rdy_mode = 0;
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle(2);
    chk("head_a5", bus.out_data, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(3);
`ifdef SERIAL_WORD_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0, 0);
    idle(2);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    idle(2);
`endif
    rdy_mode = 1;
    idle(6);

    // Fill to DEPTH, overflow on the extra frame, then push+pop while full.
    rdy_mode = 0;
    for (int i = 0; i <= DEPTH; i++) send_frame(WIDTH'(i), 1'b1, 1'b1, 0);
    idle(2);
    chk("full_count", count, DEPTH);
    chk("full_head", bus.out_data, 0);
    rdy_mode = 3;
    send_frame(8'h55, 1'b1, 1'b1, 0);
    rdy_mode = 1;
    idle(DEPTH + 6);

    send_frame(8'h5A, 1'b1, 1'b1, 2);
    idle(4);

    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      send_frame(WIDTH'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 1;
    idle(DEPTH + 6);

    // Asynchronous reset mid-frame with words buffered.
    rdy_mode = 0;
    send_frame(8'h11, 1'b1, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    idle(2);
    w77 = 8'h77;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = WIDTH - 1; i >= WIDTH - 4; i--) drive(1'b1, w77[i], 1'b0);
    @(negedge clk);
    #1;
    in_rst = 1'b1;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    wq.delete();
    pq.delete();
    pend = 0;
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    in_rst = 1'b0;
    rdy_mode = 1;
    send_frame(8'h81, 1'b1, 1'b1, 0);
    idle(6);

    chk("words_left", wq.size(), 0);
    chk("pulses_left", pq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
